// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and constants for the instruction-fetch stage.
//   if_state_e   fetch FSM state encoding
//   RESET_PC_DEF default PC after reset
//   NOP_INST_DEF instruction presented while nothing valid is held
//   sel_word     picks the 32-bit word of a fetched doubleword by pc[2]
package if_stage_pkg;

  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

  function automatic logic [31:0] sel_word(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction bus between the fetch stage and memory.
//   if_req_valid / if_req_ready / if_req_addr : request handshake, 8-byte aligned address
//   if_resp_valid / if_resp_data              : one 64-bit response per accepted request
// Modports: master = fetch stage, slave = memory side.
interface if_stage_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [63:0] if_resp_data;

  modport master (
    output if_req_valid,
    output if_req_addr,
    input  if_req_ready,
    input  if_resp_valid,
    input  if_resp_data
  );

  modport slave (
    input  if_req_valid,
    input  if_req_addr,
    output if_req_ready,
    output if_resp_valid,
    output if_resp_data
  );

endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage feeding id_stage.
// Owns the PC, issues one fetch at a time, holds the fetched word until id_stage
// accepts it, and applies redirects from later stages.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   redirect_valid   taken branch/jump resolved this cycle
//   redirect_pc      redirect target (bits [1:0] dropped)
//   id_ready         id_stage accepts the held instruction
//   bus              instruction bus (master side)
//   inst_valid       inst/inst_addr carry a valid instruction
//   inst             instruction word (NOP_INST while inst_valid=0)
//   inst_addr        PC of inst
//
// state   | meaning
// IF_IDLE | one cycle after reset before the first request
// IF_REQ  | request driven from pc, waiting for bus acceptance
// IF_WAIT | request accepted, waiting for the response
// IF_HOLD | instruction held for id_stage
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  input  logic              id_ready,
  if_stage_if.master        bus,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [63:0]       inst_addr
);

  if_state_e   state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_addr_q, inst_addr_d;
  logic [63:0] redir_pc;

  assign redir_pc = redirect_pc & ~64'h3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IF_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_addr_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    case (state_q)
      IF_IDLE: begin
        state_d = IF_REQ;
        if (redirect_valid) pc_d = redir_pc;
      end
      IF_REQ: begin
        if (redirect_valid) pc_d = redir_pc;
        if (bus.if_req_ready) begin
          state_d = IF_WAIT;
          // Request already went out with the old pc; its response must be dropped.
          if (redirect_valid) kill_d = 1'b1;
        end
      end
      IF_WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (bus.if_resp_valid) begin
            kill_d  = 1'b0;
            state_d = IF_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (bus.if_resp_valid) begin
          kill_d  = 1'b0;
          state_d = IF_REQ;
          if (!kill_q) begin
            inst_valid_d = 1'b1;
            inst_d       = sel_word(bus.if_resp_data, pc_q[2]);
            inst_addr_d  = pc_q;
            pc_d         = pc_q + 64'd4;
            state_d      = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        if (redirect_valid) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
          pc_d         = redir_pc;
          state_d      = IF_REQ;
        end else if (id_ready) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
          state_d      = IF_REQ;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  assign bus.if_req_valid = (state_q == IF_REQ);
  assign bus.if_req_addr  = {pc_q[63:3], 3'b000};
  assign inst_valid       = inst_valid_q;
  assign inst             = inst_q;
  assign inst_addr        = inst_addr_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;

  if_stage_if bus ();

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .bus            (bus.master),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_addr      (inst_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt;
  int          fail_cnt;
  int          total_cnt;
  int          cycle;
  bit          pend;
  int          pend_cnt;
  int          lat;
  logic [63:0] pend_addr;
  int          hold_cyc1;
  int          hold_cyc2;

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h00500093_00000013;
    return {a[31:0] ^ 32'hC0DE_0001, a[31:0] ^ 32'h0BAD_F00D};
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] pc);
    logic [63:0] d;
    d = mem_data({pc[63:3], 3'b000});
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.addr = pc;
    e.word = exp_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score any transfer happening this cycle, advance, then run the memory model.
  task automatic tick();
    logic        acc;
    logic [63:0] acc_addr;
    exp_t        e;
    acc      = bus.if_req_valid && bus.if_req_ready;
    acc_addr = bus.if_req_addr;
    if (inst_valid && id_ready && !redirect_valid) begin
      chk("sb_xfer_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_inst_addr", inst_addr, e.addr);
        chk("sb_inst", 64'(inst), 64'(e.word));
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    bus.if_resp_valid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = acc_addr;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.if_resp_valid = 1'b1;
        bus.if_resp_data  = mem_data(pend_addr);
        pend              = 1'b0;
      end
    end
  endtask

  initial begin
    exp_t dropped;
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0; cycle = 0;
    pend = 1'b0; pend_cnt = 0; lat = 1; pend_addr = '0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    bus.if_req_ready = 1'b0; bus.if_resp_valid = 1'b0; bus.if_resp_data = '0;

    // Reset for 3 cycles
    repeat (3) tick();
    chk("rst_req_valid", 64'(bus.if_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'h13);
    chk("rst_inst_addr", inst_addr, 64'd0);

    // Basic fetch flow
    rst = 1'b0; bus.if_req_ready = 1'b1; id_ready = 1'b1;
    tick();
    chk("t1_req_valid", 64'(bus.if_req_valid), 64'd1);
    chk("t1_req_addr", bus.if_req_addr, 64'h8000_0000);
    push_exp(64'h8000_0000);
    tick();
    chk("t1_wait_no_req", 64'(bus.if_req_valid), 64'd0);
    tick();
    hold_cyc1 = cycle;
    chk("t1_inst_valid", 64'(inst_valid), 64'd1);
    chk("t1_inst0", 64'(inst), 64'h0000_0013);
    chk("t1_addr0", inst_addr, 64'h8000_0000);
    tick();
    chk("t1_req2_addr", bus.if_req_addr, 64'h8000_0000);
    chk("t1_nop_after_xfer", 64'(inst), 64'h13);
    push_exp(64'h8000_0004);
    tick();
    tick();
    hold_cyc2 = cycle;
    chk("t1_inst1", 64'(inst), 64'h0050_0093);
    chk("t1_addr1", inst_addr, 64'h8000_0004);
    chk("t1_throughput", 64'(hold_cyc2 - hold_cyc1), 64'd3);
    bus.if_req_ready = 1'b0;
    tick();

    // Bus stalls the request for 4 cycles
    for (int i = 0; i < 4; i++) begin
      chk("t2_req_valid_stable", 64'(bus.if_req_valid), 64'd1);
      chk("t2_req_addr_stable", bus.if_req_addr, 64'h8000_0008);
      tick();
    end
    bus.if_req_ready = 1'b1;
    push_exp(64'h8000_0008);
    tick();
    id_ready = 1'b0;
    tick();

    // id_stage stalls the held instruction for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk("t3_inst_valid", 64'(inst_valid), 64'd1);
      chk("t3_inst", 64'(inst), 64'(exp_word(64'h8000_0008)));
      chk("t3_inst_addr", inst_addr, 64'h8000_0008);
      chk("t3_no_req", 64'(bus.if_req_valid), 64'd0);
      tick();
    end
    id_ready = 1'b1;
    tick();
    chk("t3_next_req_addr", bus.if_req_addr, 64'h8000_0008);

    // Redirect while waiting, response arrives the cycle after
    lat = 2;
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("t4_resp_present", 64'(bus.if_resp_valid), 64'd1);
    tick();
    chk("t4_discarded", 64'(inst_valid), 64'd0);
    chk("t4_req_valid", 64'(bus.if_req_valid), 64'd1);
    chk("t4_req_addr", bus.if_req_addr, 64'h8000_0100);
    lat = 1;
    push_exp(64'h8000_0100);
    tick();
    tick();
    chk("t4_inst_addr", inst_addr, 64'h8000_0100);
    chk("t4_inst", 64'(inst), 64'(exp_word(64'h8000_0100)));

    // Redirect together with id_ready in HOLD: held instruction is dropped
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    dropped = exp_q.pop_front();
    tick();
    redirect_valid = 1'b0;
    chk("t5_inst_valid", 64'(inst_valid), 64'd0);
    chk("t5_inst_nop", 64'(inst), 64'h13);
    chk("t5_req_addr", bus.if_req_addr, 64'h8000_0200);
    push_exp(64'h8000_0200);
    tick();
    tick();
    tick();

    // Reset while waiting; stale response afterwards is ignored
    lat = 2;
    tick();
    rst = 1'b1; pend = 1'b0;
    tick();
    chk("t6_rst_req_valid", 64'(bus.if_req_valid), 64'd0);
    chk("t6_rst_inst_valid", 64'(inst_valid), 64'd0);
    rst = 1'b0; bus.if_req_ready = 1'b0;
    bus.if_resp_valid = 1'b1; bus.if_resp_data = 64'hDEAD_BEEF_0BAD_CAFE;
    tick();
    bus.if_resp_valid = 1'b1;
    tick();
    chk("t6_stale_ignored", 64'(inst_valid), 64'd0);
    chk("t6_req_valid", 64'(bus.if_req_valid), 64'd1);
    chk("t6_restart_addr", bus.if_req_addr, 64'h8000_0000);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("t6_top_req_addr", bus.if_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    bus.if_req_ready = 1'b1; lat = 1;
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    chk("t6_top_inst_addr", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("t6_wrap_req_addr", bus.if_req_addr, 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
